// File: rtl/mm_pkg.sv
// Shared types and scoring helpers for the Mastermind codebreaker.
// Codes are four 3-bit colour digits, digit 0 in the least significant bits.
package mm_pkg;

  localparam int CODE_W  = 12;
  localparam int COLOR_W = 3;
  localparam int NPOS    = 4;
  localparam int NCOLOR  = 8;

  localparam logic [COLOR_W-1:0] FB_RED   = 3'o7;
  localparam logic [COLOR_W-1:0] FB_WHITE = 3'o1;
  localparam logic [COLOR_W-1:0] FB_NONE  = 3'o0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEARCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] white;
  } score_t;

  typedef struct packed {
    logic [CODE_W-1:0] guess;
    logic [2:0]        red;
    logic [2:0]        white;
  } hist_entry_t;

  // Grader: red = exact position matches; white = colour overlap minus red.
  function automatic score_t grade(input logic [CODE_W-1:0] a, input logic [CODE_W-1:0] b);
    score_t     s;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
    logic [2:0] overlap;
    s.red   = '0;
    overlap = '0;
    for (int p = 0; p < NPOS; p++) begin
      if (a[p*COLOR_W +: COLOR_W] == b[p*COLOR_W +: COLOR_W]) s.red = s.red + 3'd1;
    end
    for (int c = 0; c < NCOLOR; c++) begin
      cnt_a = '0;
      cnt_b = '0;
      for (int p = 0; p < NPOS; p++) begin
        if (a[p*COLOR_W +: COLOR_W] == COLOR_W'(c)) cnt_a = cnt_a + 3'd1;
        if (b[p*COLOR_W +: COLOR_W] == COLOR_W'(c)) cnt_b = cnt_b + 3'd1;
      end
      overlap = overlap + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
    end
    s.white = overlap - s.red;
    return s;
  endfunction

  // The game reports pegs in arbitrary slots, so only the counts matter.
  function automatic score_t decode_feedback(input logic [COLOR_W-1:0] f0,
                                             input logic [COLOR_W-1:0] f1,
                                             input logic [COLOR_W-1:0] f2,
                                             input logic [COLOR_W-1:0] f3);
    score_t                         s;
    logic [NPOS-1:0][COLOR_W-1:0]   fb;
    fb      = {f3, f2, f1, f0};
    s.red   = '0;
    s.white = '0;
    for (int p = 0; p < NPOS; p++) begin
      case (fb[p])
        FB_RED:   s.red   = s.red + 3'd1;
        FB_WHITE: s.white = s.white + 3'd1;
        FB_NONE:  ;
        default:  ;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/mm_history.sv
// Register file of graded guesses; writes append at the current count.
// Reads are combinational so the search can check one entry per cycle.
module mm_history
  import mm_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  hist_entry_t      wr_data,
  input  logic [CNT_W-1:0] rd_idx,
  output hist_entry_t      rd_data,
  output logic [CNT_W-1:0] count
);

  hist_entry_t      entry_q [DEPTH];
  hist_entry_t      entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic hit;
    assign hit          = wr_en && (count_q == CNT_W'(gi));
    assign entry_d[gi]  = hit ? wr_data : entry_q[gi];
    assign valid_d[gi]  = !clr && (valid_q[gi] || hit);
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_en && (count_q < CNT_W'(DEPTH))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_idx == CNT_W'(i))) rd_data = entry_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mm_codebreaker.sv
// Automatic Mastermind player: proposes the first code consistent with all
// feedback so far, retrying grade_it when the game does not answer.
module mm_codebreaker
  import mm_pkg::*;
#(
  parameter logic [CODE_W-1:0] FIRST_GUESS  = 12'o0011,
  parameter int                MAX_GUESS    = 10,
  parameter int                RESP_TIMEOUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  output logic              start_game,
  output logic              grade_it,
  output logic [CODE_W-1:0] guess,
  input  logic [2:0]        feedback0,
  input  logic [2:0]        feedback1,
  input  logic [2:0]        feedback2,
  input  logic [2:0]        feedback3,
  input  logic [3:0]        round_number,
  input  logic              won,
  input  logic              lost,
  output logic              busy,
  output logic              solved,
  output logic              failed,
  output logic [3:0]        guesses_used
);

  localparam int CNT_W = 4;
  localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] guess_q, guess_d;
  logic [CODE_W:0]   examined_q, examined_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [3:0]        round_cap_q, round_cap_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              start_game_q, start_game_d;
  logic              grade_it_q, grade_it_d;
  logic              busy_q, busy_d;
  logic              solved_q, solved_d;
  logic              failed_q, failed_d;

  logic              hist_clr;
  logic              hist_wr;
  hist_entry_t       hist_wr_data;
  hist_entry_t       hist_rd_data;
  logic [CNT_W-1:0]  hist_count;
  score_t            cand_score;
  score_t            fb_score;
  logic              response;
  logic              cand_ok;

  mm_history #(
    .DEPTH (MAX_GUESS),
    .CNT_W (CNT_W)
  ) u_history (
    .clock   (clock),
    .reset   (reset),
    .clr     (hist_clr),
    .wr_en   (hist_wr),
    .wr_data (hist_wr_data),
    .rd_idx  (idx_q),
    .rd_data (hist_rd_data),
    .count   (hist_count)
  );

  assign cand_score   = grade(cand_q, hist_rd_data.guess);
  assign cand_ok      = (cand_score.red == hist_rd_data.red) && (cand_score.white == hist_rd_data.white);
  assign fb_score     = decode_feedback(feedback0, feedback1, feedback2, feedback3);
  assign response     = (round_number != round_cap_q) || won || lost;
  assign hist_wr_data = {guess_q, fb_score.red, fb_score.white};

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    guess_d     = guess_q;
    examined_d  = examined_q;
    idx_d       = idx_q;
    round_cap_d = round_cap_q;
    timer_d     = timer_q;
    solved_d    = solved_q;
    failed_d    = failed_q;
    hist_clr    = 1'b0;
    hist_wr     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d    = ST_START;
          hist_clr   = 1'b1;
          cand_d     = FIRST_GUESS;
          examined_d = '0;
          idx_d      = '0;
          solved_d   = 1'b0;
          failed_d   = 1'b0;
        end
      end
      ST_START: state_d = ST_SEARCH;
      ST_SEARCH: begin
        // The MSB of examined flags that every code has been tried once.
        if (examined_q[CODE_W]) begin
          failed_d = 1'b1;
          state_d  = ST_DONE;
        end else if (idx_q == hist_count) begin
          guess_d     = cand_q;
          round_cap_d = round_number;
          state_d     = ST_ISSUE;
        end else if (cand_ok) begin
          idx_d = idx_q + CNT_W'(1);
        end else begin
          cand_d     = cand_q + CODE_W'(1);
          examined_d = examined_q + (CODE_W+1)'(1);
          idx_d      = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        if (response) begin
          if (won) begin
            solved_d = 1'b1;
            state_d  = ST_DONE;
          end else if (lost) begin
            failed_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            hist_wr = 1'b1;
            if (hist_count == CNT_W'(MAX_GUESS - 1)) begin
              failed_d = 1'b1;
              state_d  = ST_DONE;
            end else begin
              cand_d     = cand_q + CODE_W'(1);
              examined_d = examined_q + (CODE_W+1)'(1);
              idx_d      = '0;
              state_d    = ST_SEARCH;
            end
          end
        end else if (timer_q == TMR_W'(RESP_TIMEOUT - 1)) begin
          state_d = ST_ISSUE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_game_d = (state_d == ST_START);
    grade_it_d   = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cand_q       <= FIRST_GUESS;
      guess_q      <= '0;
      examined_q   <= '0;
      idx_q        <= '0;
      round_cap_q  <= '0;
      timer_q      <= '0;
      start_game_q <= 1'b0;
      grade_it_q   <= 1'b0;
      busy_q       <= 1'b0;
      solved_q     <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      guess_q      <= guess_d;
      examined_q   <= examined_d;
      idx_q        <= idx_d;
      round_cap_q  <= round_cap_d;
      timer_q      <= timer_d;
      start_game_q <= start_game_d;
      grade_it_q   <= grade_it_d;
      busy_q       <= busy_d;
      solved_q     <= solved_d;
      failed_q     <= failed_d;
    end
  end

  assign start_game   = start_game_q;
  assign grade_it     = grade_it_q;
  assign guess        = guess_q;
  assign busy         = busy_q;
  assign solved       = solved_q;
  assign failed       = failed_q;
  assign guesses_used = hist_count;

endmodule

// File: tb/tb_mm_codebreaker.sv
// Plays the codebreaker against a behavioural game and checks every guess
// against a brute-force "first consistent code" reference.
module tb_mm_codebreaker;

  localparam logic [11:0] FIRST = 12'o0011;
  localparam int MAXG = 10;
  localparam int TMO  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go    = 1'b0;
  logic [2:0]  feedback0 = '0, feedback1 = '0, feedback2 = '0, feedback3 = '0;
  logic [3:0]  round_number = '0;
  logic        won = 1'b0, lost = 1'b0;

  logic        start_game, grade_it, busy, solved, failed;
  logic [11:0] guess;
  logic [3:0]  guesses_used;
  logic        start_game_b, grade_it_b, busy_b, solved_b, failed_b;
  logic [11:0] guess_b;
  logic [3:0]  guesses_used_b;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [11:0] g;
    int          r;
    int          w;
  } hent_t;

  hent_t hist[$];

  mm_codebreaker #(.FIRST_GUESS(FIRST), .MAX_GUESS(MAXG), .RESP_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .go(go), .start_game(start_game), .grade_it(grade_it),
    .guess(guess), .feedback0(feedback0), .feedback1(feedback1), .feedback2(feedback2),
    .feedback3(feedback3), .round_number(round_number), .won(won), .lost(lost),
    .busy(busy), .solved(solved), .failed(failed), .guesses_used(guesses_used)
  );

  mm_codebreaker #(.FIRST_GUESS(FIRST), .MAX_GUESS(2), .RESP_TIMEOUT(TMO)) dut_short (
    .clock(clock), .reset(reset), .go(go), .start_game(start_game_b), .grade_it(grade_it_b),
    .guess(guess_b), .feedback0(feedback0), .feedback1(feedback1), .feedback2(feedback2),
    .feedback3(feedback3), .round_number(round_number), .won(won), .lost(lost),
    .busy(busy_b), .solved(solved_b), .failed(failed_b), .guesses_used(guesses_used_b)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Classic peg-marking scorer: exact hits first, then unmatched colour hits.
  function automatic void ref_grade(input logic [11:0] a, input logic [11:0] b,
                                    output int red, output int white);
    int da[4];
    int db[4];
    bit ua[4];
    bit ub[4];
    bit hit;
    red = 0;
    white = 0;
    for (int p = 0; p < 4; p++) begin
      da[p] = int'(a[p*3 +: 3]);
      db[p] = int'(b[p*3 +: 3]);
      ua[p] = (da[p] == db[p]);
      ub[p] = ua[p];
      if (ua[p]) red++;
    end
    for (int p = 0; p < 4; p++) begin
      hit = 1'b0;
      for (int q = 0; q < 4; q++) begin
        if (!ua[p] && !ub[q] && !hit && da[p] == db[q]) begin
          ub[q] = 1'b1;
          hit = 1'b1;
          white++;
        end
      end
    end
  endfunction

  function automatic int first_consistent(input hent_t h[$]);
    int r, w;
    bit ok;
    logic [11:0] c;
    for (int k = 0; k < 4096; k++) begin
      c  = FIRST + 12'(k);
      ok = 1'b1;
      foreach (h[j]) begin
        if (ok) begin
          ref_grade(c, h[j].g, r, w);
          if (r != h[j].r || w != h[j].w) ok = 1'b0;
        end
      end
      if (ok) return int'(c);
    end
    return -1;
  endfunction

  // Guesses the ideal player needs for this secret, or limit+1 if more.
  function automatic int ref_play(input logic [11:0] secret, input int limit);
    hent_t h[$];
    hent_t e;
    int c, r, w;
    for (int n = 1; n <= limit; n++) begin
      c = first_consistent(h);
      if (c < 0) return limit + 1;
      if (12'(c) == secret) return n;
      ref_grade(12'(c), secret, r, w);
      e.g = 12'(c);
      e.r = r;
      e.w = w;
      h.push_back(e);
    end
    return limit + 1;
  endfunction

  task automatic set_feedback(input int r, input int w);
    logic [2:0] fb[4];
    logic [2:0] t;
    int j;
    for (int p = 0; p < 4; p++) fb[p] = (p < r) ? 3'o7 : (p < r + w) ? 3'o1 : 3'o0;
    for (int p = 3; p > 0; p--) begin
      j = int'($urandom_range(p, 0));
      t = fb[p];
      fb[p] = fb[j];
      fb[j] = t;
    end
    feedback0 = fb[0];
    feedback1 = fb[1];
    feedback2 = fb[2];
    feedback3 = fb[3];
  endtask

  task automatic run_game(input string tag, input logic [11:0] secret, input int lose_at,
                          input bit ignore_first, input bit zero_fb);
    int cyc, pulses, pulses_b, resp_cnt, countdown, last_pulse, r, w, exp_code, stray;
    logic [11:0] last_guess;
    bit prev_pulse, game_won, done;
    hent_t e;
    hist.delete();
    pulses = 0; pulses_b = 0; resp_cnt = 0; countdown = 0; last_pulse = -100;
    last_guess = '0; game_won = 1'b0; done = 1'b0; stray = 0;
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    check_eq({tag, "/start_pulse"}, 32'(start_game), 32'd1);
    round_number = '0;
    won = 1'b0;
    lost = 1'b0;
    set_feedback(0, 0);
    prev_pulse = 1'b1;
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (grade_it_b) pulses_b++;
      if (cyc == 1) check_eq({tag, "/start_once"}, 32'(start_game), 32'd0);
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          resp_cnt++;
          if (zero_fb) begin
            r = 0;
            w = 0;
          end else begin
            ref_grade(last_guess, secret, r, w);
          end
          set_feedback(r, w);
          round_number = round_number + 4'd1;
          if (!zero_fb && r == 4) begin
            won = 1'b1;
            game_won = 1'b1;
          end
          if (resp_cnt == lose_at) lost = 1'b1;
          if (!won && !lost) begin
            e.g = last_guess;
            e.r = r;
            e.w = w;
            hist.push_back(e);
          end
        end
      end
      if (grade_it) begin
        pulses++;
        check_eq({tag, "/spacing"}, 32'(prev_pulse), 32'd0);
        if (pulses == 1) check_eq({tag, "/first_lat"}, 32'(cyc), 32'd2);
        exp_code = first_consistent(hist);
        check_eq({tag, "/guess"}, 32'(guess), 32'(exp_code));
        if (ignore_first && pulses == 2) begin
          check_eq({tag, "/repulse_gap"}, 32'(cyc - last_pulse), 32'(TMO + 1));
          check_eq({tag, "/repulse_guess"}, 32'(guess), 32'(last_guess));
        end
        last_pulse = cyc;
        last_guess = guess;
        if (!(ignore_first && pulses == 1)) countdown = int'($urandom_range(4, 1));
      end
      prev_pulse = grade_it || start_game;
      if (!busy) done = 1'b1;
    end
    check_eq({tag, "/finished"}, 32'(done), 32'd1);
    repeat (6) begin
      @(negedge clock);
      if (grade_it) stray++;
      if (grade_it_b) pulses_b++;
    end
    check_eq({tag, "/no_stray"}, 32'(stray), 32'd0);
    check_eq({tag, "/solved"}, 32'(solved), 32'(game_won));
    check_eq({tag, "/failed"}, 32'(failed), 32'(!game_won));
    check_eq({tag, "/used"}, 32'(guesses_used), 32'(hist.size()));
    check_eq({tag, "/busy"}, 32'(busy), 32'd0);
    if (!game_won && !lost && hist.size() < MAXG)
      check_eq({tag, "/exhausted"}, 32'(first_consistent(hist)), 32'hffff_ffff);
    if (zero_fb) begin
      check_eq({tag, "/short_used"}, 32'(guesses_used_b), 32'd2);
      check_eq({tag, "/short_failed"}, 32'(failed_b), 32'd1);
      check_eq({tag, "/short_solved"}, 32'(solved_b), 32'd0);
      check_eq({tag, "/short_pulses"}, 32'(pulses_b), 32'd2);
      check_eq({tag, "/short_busy"}, 32'(busy_b), 32'd0);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "/start_game"}, 32'(start_game), 32'd0);
    check_eq({tag, "/grade_it"}, 32'(grade_it), 32'd0);
    check_eq({tag, "/guess"}, 32'(guess), 32'd0);
    check_eq({tag, "/busy"}, 32'(busy), 32'd0);
    check_eq({tag, "/solved"}, 32'(solved), 32'd0);
    check_eq({tag, "/failed"}, 32'(failed), 32'd0);
    check_eq({tag, "/used"}, 32'(guesses_used), 32'd0);
  endtask

  initial begin
    logic [11:0] s;
    bit picked;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_idle("reset");
    check_eq("reset_b/outs", 32'({start_game_b, grade_it_b, busy_b, solved_b, failed_b}), 32'd0);
    check_eq("reset_b/guess", 32'(guess_b), 32'd0);
    check_eq("reset_b/used", 32'(guesses_used_b), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("post_reset/busy", 32'(busy), 32'd0);

    run_game("s0011", 12'o0011, 0, 1'b0, 1'b0);
    run_game("s0501", 12'o0501, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) run_game("rand", 12'($urandom), 0, 1'b0, 1'b0);
    run_game("ignore1", 12'($urandom), 0, 1'b1, 1'b0);

    s = 12'o7654;
    picked = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!picked) begin
        s = 12'($urandom);
        if (ref_play(s, 3) > 3) picked = 1'b1;
      end
    end
    run_game("lose3", s, 3, 1'b0, 1'b0);
    check_eq("lose3/used2", 32'(guesses_used), 32'd2);

    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_idle("mid_reset");
    repeat (3) begin
      @(negedge clock);
      check_eq("mid_reset/quiet", 32'({start_game, grade_it}), 32'd0);
    end
    reset = 1'b1;
    run_game("after_rst", 12'($urandom), 0, 1'b0, 1'b0);

    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_game("nowin", 12'o0000, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
